trace_replay: RTL and testbench

//  Plays back a ROM-resident command trace, one 4-bit-opcode entry at a time. It drives a

---
 rtl/trace_replay_if.sv | 33 +++
 rtl/trace_replay.sv | 163 ++++++++++++++++
 tb/tb_trace_replay.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_replay_if.sv
// ---------------------------------------------------------------------------
// trace_replay_if
//   Bundles the three data-path ports of trace_replay:
//     producer side (replay -> DUT) : v_o, data_o, yumi_i   (valid/yumi)
//     consumer side (DUT -> replay) : v_i, data_i, ready_o  (valid/ready)
//     trace ROM                     : rom_addr_o, rom_data_i (combinational read)
//   Signal suffixes are given from the replay block's point of view.
//   modport master : used by trace_replay itself
//   modport slave  : used by the environment (ROM model, DUT, testbench)
// ---------------------------------------------------------------------------
interface trace_replay_if #(
  parameter int payload_width_p  = 80,
  parameter int rom_addr_width_p = 20
);
  logic                          v_i;
  logic [payload_width_p-1:0]    data_i;
  logic                          ready_o;
  logic                          v_o;
  logic [payload_width_p-1:0]    data_o;
  logic                          yumi_i;
  logic [rom_addr_width_p-1:0]   rom_addr_o;
  logic [payload_width_p+3:0]    rom_data_i;

  modport master (
    input  v_i, data_i, yumi_i, rom_data_i,
    output ready_o, v_o, data_o, rom_addr_o
  );

  modport slave (
    output v_i, data_i, yumi_i, rom_data_i,
    input  ready_o, v_o, data_o, rom_addr_o
  );
endinterface

// File: rtl/trace_replay.sv
// ---------------------------------------------------------------------------
// trace_replay
//   Replays a command trace held in an external, combinationally read ROM.
//   Each ROM word is {op[3:0], payload}. The entry at rom_addr_o is decoded
//   every cycle; only that entry is acted on.
//     0 NOP    : advance
//     1 SEND   : v_o=1, data_o=payload, advance on yumi_i
//     2 RECV   : ready_o=1, advance on v_i, flag error if data_i != payload
//     3 DONE   : set sticky done, hold address
//     4 FINISH : as DONE; in simulation also ends the run one edge later
//     5 WAIT   : advance when cnt is zero, otherwise decrement cnt
//     6 INIT   : load cnt from payload[15:0], advance
//     others   : flag error, advance
//   Replay runs while en_i=1 and done_o=0; otherwise all state holds and
//   both handshakes are deasserted.
//
// Ports
//   clk_i       clock, rising edge
//   reset_n_i   asynchronous active-low reset
//   en_i        replay enable (0 = freeze)
//   bus         trace_replay_if.master: producer, consumer and ROM ports
//   done_o      sticky: DONE/FINISH reached
//   error_o     sticky: RECV mismatch or illegal opcode
//
// Configuration
//   TRACE_REPLAY_DEBUG_EN : when defined, prints every completed entry and
//                           the expected/actual data of a RECV mismatch.
//                           Functional behaviour is unchanged.
// ---------------------------------------------------------------------------
module trace_replay #(
  parameter int payload_width_p  = 80,
  parameter int rom_addr_width_p = 20
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_i,
  trace_replay_if.master       bus,
  output logic                 done_o,
  output logic                 error_o
);

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_SEND   = 4'h1,
    OP_RECV   = 4'h2,
    OP_DONE   = 4'h3,
    OP_FINISH = 4'h4,
    OP_WAIT   = 4'h5,
    OP_INIT   = 4'h6
  } op_e;

  localparam logic [rom_addr_width_p-1:0] addr_one_lp = rom_addr_width_p'(1);

  logic [rom_addr_width_p-1:0] addr_q, addr_d;
  logic [15:0]                 cnt_q,  cnt_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;

  op_e                         op;
  logic [payload_width_p-1:0]  payload;
  logic                        active;

  assign op      = op_e'(bus.rom_data_i[payload_width_p+3:payload_width_p]);
  assign payload = bus.rom_data_i[payload_width_p-1:0];

  // reset_n_i is folded in so both handshakes are low while reset is held.
  assign active  = reset_n_i & en_i & ~done_q;

  assign bus.data_o     = payload;
  assign bus.rom_addr_o = addr_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    bus.v_o     = 1'b0;
    bus.ready_o = 1'b0;

    if (active) begin
      case (op)
        OP_NOP: addr_d = addr_q + addr_one_lp;

        OP_SEND: begin
          bus.v_o = 1'b1;
          if (bus.yumi_i) addr_d = addr_q + addr_one_lp;
        end

        OP_RECV: begin
          bus.ready_o = 1'b1;
          if (bus.v_i) begin
            addr_d = addr_q + addr_one_lp;
            if (bus.data_i != payload) error_d = 1'b1;
          end
        end

        OP_DONE, OP_FINISH: done_d = 1'b1;

        OP_WAIT: begin
          if (cnt_q == 16'd0) addr_d = addr_q + addr_one_lp;
          else                cnt_d  = cnt_q - 16'd1;
        end

        OP_INIT: begin
          cnt_d  = payload[15:0];
          addr_d = addr_q + addr_one_lp;
        end

        // Unknown opcodes are reported and then skipped like a NOP.
        default: begin
          error_d = 1'b1;
          addr_d  = addr_q + addr_one_lp;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

`ifndef SYNTHESIS
  // FINISH ends the simulation on the edge after the one that retires it.
  logic finish_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      finish_q <= 1'b0;
    end else begin
      if (finish_q) $finish;
      finish_q <= active && (op == OP_FINISH);
    end
  end
`endif

`ifdef TRACE_REPLAY_DEBUG_EN
  // An entry is complete when the address moves or done is being set.
  always_ff @(posedge clk_i) begin
    if (active && ((addr_d != addr_q) || (done_d && !done_q)))
      $display("%0t trace_replay: addr=%0h op=%0h payload=%0h",
               $time, addr_q, op, payload);
    if (active && (op == OP_RECV) && bus.v_i && (bus.data_i != payload))
      $display("%0t trace_replay: recv mismatch addr=%0h expected=%0h actual=%0h",
               $time, addr_q, payload, bus.data_i);
  end
`endif

endmodule

// File: tb/tb_trace_replay.sv
module tb_trace_replay;

  localparam int W = 80;
  localparam int A = 4;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic done, error;
  logic yumi_tie = 1'b0;
  logic yumi_drv = 1'b0;

  trace_replay_if #(.payload_width_p(W), .rom_addr_width_p(A)) bus ();

  logic [W+3:0] rom [N];
  assign bus.rom_data_i = rom[bus.rom_addr_o];
  assign bus.yumi_i     = yumi_tie ? bus.v_o : yumi_drv;

  trace_replay #(.payload_width_p(W), .rom_addr_width_p(A)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .en_i      (en),
    .bus       (bus.master),
    .done_o    (done),
    .error_o   (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  logic [W-1:0] exp_q [$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] payload;
    logic         en;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         yumi;
    logic         exp_v;
    logic         exp_ready;
    logic [A-1:0] exp_addr;
    logic         exp_err;
    logic         exp_done;
    string        name;
  } vec_t;

  vec_t vecs [13];

  // Stall sequence: per-cycle enable / yumi stimulus and expected v_o / address.
  bit           st_en   [6] = '{1, 0, 0, 1, 1, 1};
  bit           st_yumi [6] = '{0, 0, 0, 0, 1, 0};
  bit           st_v    [6] = '{1, 0, 0, 1, 1, 0};
  logic [A-1:0] st_addr [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+3:0] ent(input logic [3:0] op, input logic [W-1:0] p);
    return {op, p};
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] p, input logic e,
                              input logic vi, input logic [W-1:0] di, input logic y,
                              input logic ev, input logic er, input logic [A-1:0] ea,
                              input logic ee, input logic ed, input string nm);
    vec_t v;
    v.op = op; v.payload = p; v.en = e; v.v_i = vi; v.data_i = di; v.yumi = y;
    v.exp_v = ev; v.exp_ready = er; v.exp_addr = ea; v.exp_err = ee; v.exp_done = ed;
    v.name = nm;
    return v;
  endfunction

  task automatic fill(input logic [3:0] op);
    for (int i = 0; i < N; i++) rom[i] = ent(op, '0);
  endtask

  // Leaves the bench at the negedge where reset was released (cycle 0).
  task automatic reset_dut();
    en = 1'b0; bus.v_i = 1'b0; bus.data_i = '0; yumi_drv = 1'b0; yumi_tie = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Scoreboard: pop one expected payload for every producer handshake seen.
  task automatic sb_sample(input string name);
    if (bus.v_o && bus.yumi_i) begin
      if (exp_q.size() == 0) begin
        tests++; failures++;
        $display("FAIL %s: unexpected send %0h, expected none", name, bus.data_o);
      end else begin
        check(name, bus.data_o, exp_q.pop_front());
      end
    end
  endtask

  task automatic recv_test(input string tag, input logic [W-1:0] d, input logic exp_err);
    fill(4'h3);
    rom[0] = ent(4'h2, 80'h1234);
    reset_dut();
    en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.v_i = (c == 4);
      bus.data_i = d;
      #1;
      if (c <= 4) check($sformatf("%s_ready_c%0d", tag, c), bus.ready_o, 1'b1);
      if (c == 5) begin
        check({tag, "_ready_after"}, bus.ready_o, 1'b0);
        check({tag, "_addr"}, bus.rom_addr_o, 4'd1);
        check({tag, "_error"}, error, exp_err);
      end
      if (c == 6) check({tag, "_done"}, done, 1'b1);
      @(negedge clk);
    end
    bus.v_i = 1'b0;
  endtask

  initial begin
    int first_send;
    int done_cyc;

    vecs[0]  = mk(4'h0, 80'h0,    1, 0, 80'h0,    0, 0, 0, 4'd1, 0, 0, "nop");
    vecs[1]  = mk(4'h1, 80'h1111, 1, 0, 80'h0,    1, 1, 0, 4'd1, 0, 0, "send_yumi");
    vecs[2]  = mk(4'h1, 80'h2222, 1, 0, 80'h0,    0, 1, 0, 4'd0, 0, 0, "send_stall");
    vecs[3]  = mk(4'h1, 80'h3333, 0, 0, 80'h0,    0, 0, 0, 4'd0, 0, 0, "send_frozen");
    vecs[4]  = mk(4'h2, 80'h4444, 1, 1, 80'h4444, 0, 0, 1, 4'd1, 0, 0, "recv_match");
    vecs[5]  = mk(4'h2, 80'h5555, 1, 0, 80'h0,    0, 0, 1, 4'd0, 0, 0, "recv_idle");
    vecs[6]  = mk(4'h2, 80'h8000_0000_0000_0000_0006, 1, 1, 80'h6, 0, 0, 1, 4'd1, 1, 0, "recv_msb_mismatch");
    vecs[7]  = mk(4'h2, 80'h7777, 0, 1, 80'h7778, 0, 0, 0, 4'd0, 0, 0, "recv_frozen");
    vecs[8]  = mk(4'h3, 80'h0,    1, 0, 80'h0,    0, 0, 0, 4'd0, 0, 1, "done");
    vecs[9]  = mk(4'h6, 80'h9,    1, 0, 80'h0,    0, 0, 0, 4'd1, 0, 0, "init");
    vecs[10] = mk(4'h5, 80'h0,    1, 0, 80'h0,    0, 0, 0, 4'd1, 0, 0, "wait_cnt0");
    vecs[11] = mk(4'h7, 80'h0,    1, 0, 80'h0,    0, 0, 0, 4'd1, 1, 0, "op7_illegal");
    vecs[12] = mk(4'h1, 80'hCC,   1, 1, 80'hCC,   0, 1, 0, 4'd0, 0, 0, "send_ignores_v_i");

    // ---- single-entry vectors ----
    foreach (vecs[i]) begin
      fill(4'h3);
      rom[0] = ent(vecs[i].op, vecs[i].payload);
      reset_dut();
      en = vecs[i].en; bus.v_i = vecs[i].v_i; bus.data_i = vecs[i].data_i; yumi_drv = vecs[i].yumi;
      #1;
      check({vecs[i].name, "_v"},     bus.v_o,     vecs[i].exp_v);
      check({vecs[i].name, "_ready"}, bus.ready_o, vecs[i].exp_ready);
      check({vecs[i].name, "_data"},  bus.data_o,  vecs[i].payload);
      @(negedge clk);
      en = 1'b0; bus.v_i = 1'b0; yumi_drv = 1'b0;
      #1;
      check({vecs[i].name, "_addr"},  bus.rom_addr_o, vecs[i].exp_addr);
      check({vecs[i].name, "_error"}, error,          vecs[i].exp_err);
      check({vecs[i].name, "_done"},  done,           vecs[i].exp_done);
    end

    // ---- back-to-back sends with yumi tied to v ----
    fill(4'h3);
    rom[0] = ent(4'h1, 80'hA5);
    rom[1] = ent(4'h1, 80'h5A);
    exp_q.delete();
    exp_q.push_back(80'hA5);
    exp_q.push_back(80'h5A);
    reset_dut();
    check("reset_addr", bus.rom_addr_o, 4'd0);
    check("reset_done", done, 1'b0);
    en = 1'b1; yumi_tie = 1'b1;
    first_send = -1; done_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.v_o && bus.yumi_i && first_send < 0) first_send = c;
      if (c == 1) check("b2b_v_c1", bus.v_o, 1'b1);
      sb_sample("b2b_data");
      if (done && done_cyc < 0) done_cyc = c;
      @(negedge clk);
    end
    check("b2b_first_send", first_send, 0);
    check("b2b_done_cycle", done_cyc, 3);
    check("b2b_addr_hold", bus.rom_addr_o, 4'd2);
    check("b2b_sb_empty", exp_q.size(), 0);

    // ---- receive, matching and mismatching ----
    recv_test("recv_ok",  80'h1234, 1'b0);
    recv_test("recv_bad", 80'h1235, 1'b1);

    // ---- INIT 5 then WAIT: v_o first rises 7 cycles after reset release ----
    fill(4'h3);
    rom[0] = ent(4'h6, 80'h5);
    rom[1] = ent(4'h5, 80'h0);
    rom[2] = ent(4'h1, 80'h7);
    exp_q.delete();
    exp_q.push_back(80'h7);
    reset_dut();
    en = 1'b1; yumi_tie = 1'b1;
    first_send = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.v_o && first_send < 0) first_send = c;
      sb_sample("wait_data");
      @(negedge clk);
    end
    check("wait_first_v", first_send, 7);
    check("wait_sb_empty", exp_q.size(), 0);

    // ---- SEND stalled by yumi, with enable dropped mid-stall ----
    fill(4'h3);
    rom[0] = ent(4'h1, 80'hBEEF);
    exp_q.delete();
    exp_q.push_back(80'hBEEF);
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      en = st_en[c]; yumi_drv = st_yumi[c];
      #1;
      check($sformatf("stall_v_c%0d", c), bus.v_o, st_v[c]);
      check($sformatf("stall_addr_c%0d", c), bus.rom_addr_o, st_addr[c]);
      if (c < 5) check($sformatf("stall_data_c%0d", c), bus.data_o, 80'hBEEF);
      sb_sample("stall_sb");
      @(negedge clk);
    end
    yumi_drv = 1'b0;
    check("stall_sb_empty", exp_q.size(), 0);

    // ---- illegal opcode, then asynchronous reset after done ----
    fill(4'h3);
    rom[0] = ent(4'hF, 80'h0);
    rom[1] = ent(4'h0, 80'h0);
    reset_dut();
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 0) begin
        check("ill_addr_c0", bus.rom_addr_o, 4'd0);
        check("ill_err_c0", error, 1'b0);
      end
      if (c == 1) begin
        check("ill_addr_c1", bus.rom_addr_o, 4'd1);
        check("ill_err_c1", error, 1'b1);
      end
      if (c == 3) begin
        check("ill_done", done, 1'b1);
        check("ill_err_sticky", error, 1'b1);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", bus.rom_addr_o, 4'd0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_error", error, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // ---- reset while a SEND is stalled ----
    fill(4'h3);
    rom[0] = ent(4'h0, 80'h0);
    rom[1] = ent(4'h0, 80'h0);
    rom[2] = ent(4'h1, 80'h77);
    reset_dut();
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midrst_v_before", bus.v_o, 1'b1);
    check("midrst_addr_before", bus.rom_addr_o, 4'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_v_in_reset", bus.v_o, 1'b0);
    check("midrst_addr_in_reset", bus.rom_addr_o, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("midrst_addr_restart", bus.rom_addr_o, 4'd0);
    @(negedge clk);
    en = 1'b0;

    // ---- address wrap over an all-NOP ROM ----
    fill(4'h0);
    reset_dut();
    en = 1'b1;
    for (int c = 0; c < 17; c++) begin
      #1;
      if (c == 15) check("wrap_addr_top", bus.rom_addr_o, 4'd15);
      if (c == 16) begin
        check("wrap_addr_zero", bus.rom_addr_o, 4'd0);
        check("wrap_no_error", error, 1'b0);
        check("wrap_not_done", done, 1'b0);
      end
      @(negedge clk);
    end
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
